// File: rtl/sync_fifo_pkg.sv
// Shared defaults and count-update encoding for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_AEMPTY     = 3;
    localparam int unsigned DEF_AFULL      = 3;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // Simultaneous read and write leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic wr, input logic rd);
        cnt_op_e op;
        op = CNT_HOLD;
        if (wr && !rd) op = CNT_INC;
        if (rd && !wr) op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH dual-port RAM: synchronous write, registered read port.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, status flags and handshakes.
// Define SYNC_FIFO_FLUSH_EN to make the flush input clear pointers and count.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned AEMPTY     = DEF_AEMPTY,
    parameter int unsigned AFULL      = DEF_AFULL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wdata_valid,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_ack,
    input  logic                  read_req,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdata_valid,
    output logic                  fifo_full,
    output logic                  fifo_afull,
    output logic                  fifo_empty,
    output logic                  fifo_aempty
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  write_ack_q, write_ack_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  flush_en;
    logic                  wr_en;
    logic                  rd_en;

`ifdef SYNC_FIFO_FLUSH_EN
    assign flush_en = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_en     = 1'b0;
`endif

    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    assign fifo_empty  = (count_q == '0);
    assign fifo_afull  = (count_q >= CNT_W'(DEPTH - AFULL));
    assign fifo_aempty = (count_q <= CNT_W'(AEMPTY));

    // Flags come from the registered count, so a write while full is dropped
    // even when a read frees a slot on the same edge.
    assign wr_en = wdata_valid & ~fifo_full  & ~flush_en;
    assign rd_en = read_req    & ~fifo_empty & ~flush_en;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        write_ack_d   = wr_en;
        rdata_valid_d = rd_en;

        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

        unique case (cnt_op(wr_en, rd_en))
            CNT_INC: count_d = count_q + CNT_W'(1);
            CNT_DEC: count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            write_ack_q   <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            write_ack_q   <= write_ack_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign write_ack   = write_ack_q;
    assign rdata_valid = rdata_valid_q;

    sync_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (write_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (read_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and LFSR-stream checks of sync_fifo with default parameters.
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        wdata_valid = 1'b0;
    logic [15:0] write_data = '0;
    logic        write_ack;
    logic        read_req = 1'b0;
    logic [15:0] read_data;
    logic        rdata_valid;
    logic        fifo_full, fifo_afull, fifo_empty, fifo_aempty;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    sync_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .wdata_valid (wdata_valid),
        .write_data  (write_data),
        .write_ack   (write_ack),
        .read_req    (read_req),
        .read_data   (read_data),
        .rdata_valid (rdata_valid),
        .fifo_full   (fifo_full),
        .fifo_afull  (fifo_afull),
        .fifo_empty  (fifo_empty),
        .fifo_aempty (fifo_aempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wdata_valid = 1'b0;
        read_req = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [15:0] q [$];
    logic [15:0] lfsr;
    logic [15:0] exp_data;
    logic        exp_valid;
    logic        exp_ack;
    int unsigned words_in;
    int unsigned words_out;
    int unsigned cycles;

    initial begin
        do_reset();
        tick();
        check("rst_empty",  fifo_empty,  1);
        check("rst_aempty", fifo_aempty, 1);
        check("rst_full",   fifo_full,   0);
        check("rst_afull",  fifo_afull,  0);
        check("rst_rvalid", rdata_valid, 0);
        check("rst_ack",    write_ack,   0);
        check("rst_rdata",  read_data,   0);

        // Four back-to-back writes, then four reads.
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1;
            write_data  = 16'(i + 1);
            tick();
            check("w4_ack",    write_ack,   1);
            check("w4_aempty", fifo_aempty, (i + 1) <= 3);
            check("w4_empty",  fifo_empty,  0);
        end
        wdata_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_req = 1'b1;
            tick();
            check("r4_valid", rdata_valid, 1);
            check("r4_data",  read_data,   32'(i + 1));
        end
        read_req = 1'b0;
        tick();
        check("r4_valid_drop", rdata_valid, 0);
        check("r4_empty",      fifo_empty,  1);

        // Fill to 16 words, then a rejected write of 0xDEAD.
        for (int i = 0; i < 16; i++) begin
            wdata_valid = 1'b1;
            write_data  = 16'h0100 + 16'(i);
            tick();
            check("fill_ack",   write_ack,  1);
            check("fill_afull", fifo_afull, (i + 1) >= 13);
            check("fill_full",  fifo_full,  (i + 1) == 16);
        end
        write_data = 16'hDEAD;
        tick();
        check("over_ack",  write_ack, 0);
        check("over_full", fifo_full, 1);

        // Full with simultaneous read and write: read proceeds, write dropped.
        read_req   = 1'b1;
        write_data = 16'hBEEF;
        tick();
        check("fullrw_valid", rdata_valid, 1);
        check("fullrw_data",  read_data,   32'h0100);
        check("fullrw_ack",   write_ack,   0);
        check("fullrw_full",  fifo_full,   0);
        check("fullrw_afull", fifo_afull,  1);
        read_req = 1'b0;
        tick();
        check("refill_ack",  write_ack, 1);
        check("refill_full", fifo_full, 1);
        wdata_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            read_req = 1'b1;
            tick();
            check("drain_valid", rdata_valid, 1);
            check("drain_data",  read_data, (i == 16) ? 32'hBEEF : 32'h0100 + 32'(i));
        end
        read_req = 1'b0;
        tick();
        check("drain_empty", fifo_empty, 1);

        // Empty with read held: nothing returned until a word arrives.
        read_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_rd_valid", rdata_valid, 0);
        end
        wdata_valid = 1'b1;
        write_data  = 16'h1234;
        tick();
        check("wr_thru_ack",   write_ack,   1);
        check("wr_thru_valid", rdata_valid, 0);
        wdata_valid = 1'b0;
        tick();
        check("wr_thru_rvalid", rdata_valid, 1);
        check("wr_thru_data",   read_data,   32'h1234);
        read_req = 1'b0;
        tick();
        check("wr_thru_drop",  rdata_valid, 0);
        check("wr_thru_empty", fifo_empty,  1);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        wdata_valid = 1'b1;
        write_data  = 16'h5555;
        tick();
        tick();
        wdata_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_ack",   write_ack,  0);
        check("arst_empty", fifo_empty, 1);
        check("arst_aempty", fifo_aempty, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("arst_hold_empty", fifo_empty, 1);

`ifdef SYNC_FIFO_FLUSH_EN
        wdata_valid = 1'b1;
        write_data  = 16'h7777;
        tick();
        flush = 1'b1;
        tick();
        check("flush_ack",   write_ack,  0);
        check("flush_empty", fifo_empty, 1);
        flush = 1'b0;
        wdata_valid = 1'b0;
`else
        flush       = 1'b1;
        wdata_valid = 1'b1;
        write_data  = 16'h7777;
        tick();
        check("noflush_ack",   write_ack,  1);
        check("noflush_empty", fifo_empty, 0);
`endif
        do_reset();

        // LFSR-driven random traffic against a queue model.
        lfsr = 16'hACE1;
        words_in = 0;
        words_out = 0;
        cycles = 0;
        q.delete();
        while ((words_in < 2000 || q.size() != 0) && cycles < 20000) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            wdata_valid = (words_in < 2000) && lfsr[0];
            read_req    = lfsr[3] | (words_in >= 2000);
            write_data  = 16'(words_in);
            exp_valid = read_req && (q.size() != 0);
            exp_ack   = wdata_valid && (q.size() < 16);
            if (exp_valid) exp_data = q.pop_front();
            if (exp_ack) begin
                q.push_back(write_data);
                words_in++;
            end
            tick();
            cycles++;
            check("rnd_ack",   write_ack,   exp_ack);
            check("rnd_valid", rdata_valid, exp_valid);
            if (exp_valid) begin
                check("rnd_data", read_data, exp_data);
                words_out++;
            end
            check("rnd_full",  fifo_full,  q.size() == 16);
            check("rnd_empty", fifo_empty, q.size() == 0);
        end
        wdata_valid = 1'b0;
        read_req = 1'b0;
        check("rnd_words_in",  words_in,  2000);
        check("rnd_words_out", words_out, 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer that decouples a data producer from a consumer within one clock domain. Writes are qualified by a valid strobe and acknowledged; reads are requested and returned one cycle later with a valid strobe. Full, empty and programmable almost-full/almost-empty flags give producer and consumer backpressure. The block sits between any streaming source and sink sharing `clk`.

## Interface
- `ADDR_WIDTH`, 4: pointer width; must satisfy 2**ADDR_WIDTH == DEPTH.
- `DATA_WIDTH`, 16: word width.
- `DEPTH`, 16: storage words.
- `AEMPTY`, 3: almost-empty threshold, in words.
- `AFULL`, 3: almost-full margin, in free words.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `flush` in 1: synchronous clear of contents. Effective only with the macro in Configuration.
- `wdata_valid` in 1: write request.
- `write_data` in DATA_WIDTH: write word.
- `write_ack` out 1: registered pulse acknowledging an accepted write.
- `read_req` in 1: read request.
- `read_data` out DATA_WIDTH: registered read word.
- `rdata_valid` out 1: `read_data` is valid this cycle.
- `fifo_full`, `fifo_afull`, `fifo_empty`, `fifo_aempty` out 1 each: status flags.

## Operation
- State: write pointer, read pointer (ADDR_WIDTH bits each, natural wrap DEPTH-1→0), occupancy `count` (ADDR_WIDTH+1 bits, 0..DEPTH), memory array.
- Write accept: `wr_en = wdata_valid & ~fifo_full`. Store `write_data` at the write pointer, then increment the pointer. A write while full is dropped silently.
- Read accept: `rd_en = read_req & ~fifo_empty`. Register the word at the read pointer into `read_data`, then increment the pointer. A read while empty is ignored.
- Count update: `+1` on write only, `-1` on read only, unchanged on both or neither.
- Simultaneous read and write:
  - When full: the read proceeds, the write is rejected because `fifo_full` is evaluated before the edge.
  - When empty: the write proceeds and the read is ignored; no read-through.
- Flag decodes (combinational from registered `count`):
  - `fifo_full` = `count == DEPTH`.
  - `fifo_empty` = `count == 0`.
  - `fifo_afull` = `count >= DEPTH-AFULL`.
  - `fifo_aempty` = `count <= AEMPTY`.
- Data order is strictly preserved; every accepted write is read exactly once.
- `flush` (macro enabled): next edge clears pointers and count. Any same-cycle read or write is discarded, and `rdata_valid`/`write_ack` are 0 that cycle. Memory contents are not cleared.

## Timing
- Reset values:
  - Pointers, count, `read_data`: 0.
  - `rdata_valid`, `write_ack`: 0.
  - `fifo_empty`, `fifo_aempty`: 1.
  - `fifo_full`, `fifo_afull`: 0.
- Memory is not reset.
- Write: accepted at edge N; `write_ack` is high for the cycle after N; the flags reflect the new count after edge N.
- Read: accepted at edge N; `read_data` and `rdata_valid` are valid for the cycle after N; `rdata_valid` drops next cycle unless another read is accepted. Back-to-back reads give one word per cycle.
- Minimum write-to-read latency: a word written at edge N can be requested in cycle N+1 and appears after edge N+1.
- Reset asserted mid-operation: immediately returns all outputs to reset values; contents are lost.

## Configuration
- `SYNC_FIFO_FLUSH_EN` defined: `flush` behaves as in Operation.
- Not defined: `flush` is ignored (port retained, unused); contents are cleared only by `reset`.

## Structure
- Package `sync_fifo_pkg`: default width/depth/threshold constants.
- Sub-module `sync_fifo_mem`: simple dual-port RAM with synchronous write and registered read, DEPTH×DATA_WIDTH.
- Top level: pointers, count, flags, handshakes.

## Test plan
All scenarios use default parameters.
- Reset, then idle: `fifo_empty`=1, `fifo_aempty`=1, `fifo_full`=0, `fifo_afull`=0, `rdata_valid`=0, `write_ack`=0.
- Write 0x0001, 0x0002, 0x0003, 0x0004 back-to-back: `write_ack` high four cycles; `fifo_aempty` falls after the 4th write (count 4). Read 4 words: 0x0001..0x0004 in order, each one cycle after its request; `fifo_empty`=1 after.
- Write 16 words: `fifo_afull` rises at count 13, `fifo_full` at 16. A 17th write with 0xDEAD gets no `write_ack`, and 0xDEAD never appears on `read_data`.
- Full FIFO, `read_req` and `wdata_valid` together: one word is read, the write is dropped, count becomes 15. The next cycle's write is accepted.
- Empty FIFO, `read_req` held high: `rdata_valid` stays 0. A write of 0x1234 returns 0x1234 one cycle after the first read accepted following it.
- Random LFSR-driven valid/request streams for 2000 words: every word written while not full is read back in order, with no loss or duplication.
